// File: rtl/spi_master_mc.sv
// spi_master_mc: parametrised SPI master, NUM_SS selects, runtime CPOL/CPHA,
// SCLK divider, MSB/LSB order, optional chip-select hold between transfers.
// Ports: cmd_* request/handshake, cfg_* mode latched at accept,
// rsp_* one-cycle response, busy, spi_* pins (ss active low).
module spi_master_mc #(
  parameter int DATA_W    = 8,
  parameter int NUM_SS    = 2,
  parameter int DIV_W     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic              mainClk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [2:0]        cmd_ss_sel,
  input  logic              cmd_hold_ss,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [NUM_SS-1:0] spi_ss,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    cnt;
  logic [DIV_W-1:0]    div_q;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [DATA_W-1:0]   tx_sh;
  logic [DATA_W-1:0]   rx_sh;
  logic                cpol_q;
  logic                cpha_q;
  logic                hold_q;

  logic                leading;
  logic                first;
  logic                last;
  logic                do_sample;
  logic                do_shift;
  logic [DATA_W-1:0]   tx_nxt;
  logic [DATA_W-1:0]   rx_nxt;
  logic                mosi_nxt;
  logic                first_bit;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  function automatic logic [NUM_SS-1:0] ss_decode(
    input logic [2:0] sel
  );
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (sel == 3'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  // Edge 1 is leading, so an even edge_cnt (before increment) is leading.
  always_comb begin
    leading   = ~edge_cnt[0];
    first     = (edge_cnt == '0);
    last      = (edge_cnt == LAST_EDGE);
    do_sample = cpha_q ? ~leading : leading;
    do_shift  = cpha_q ? (leading & ~first)
                       : (~leading & ~last);
    if (LSB_FIRST != 0) begin
      tx_nxt    = tx_sh >> 1;
      rx_nxt    = {spi_miso, rx_sh[DATA_W-1:1]};
      mosi_nxt  = tx_nxt[0];
      first_bit = cmd_data[0];
    end else begin
      tx_nxt    = tx_sh << 1;
      rx_nxt    = {rx_sh[DATA_W-2:0], spi_miso};
      mosi_nxt  = tx_nxt[DATA_W-1];
      first_bit = cmd_data[DATA_W-1];
    end
  end

  always_ff @(posedge mainClk) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      div_q     <= '0;
      edge_cnt  <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      hold_q    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      spi_ss    <= '1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            tx_sh    <= cmd_data;
            spi_mosi <= first_bit;
            cpol_q   <= cfg_cpol;
            cpha_q   <= cfg_cpha;
            div_q    <= cfg_div;
            hold_q   <= cmd_hold_ss;
            cnt      <= cfg_div;
            edge_cnt <= '0;
            spi_sclk <= cfg_cpol;
            spi_ss   <= ss_decode(cmd_ss_sel);
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt   <= div_q;
            state <= SHIFT;
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            cnt      <= div_q;
            spi_sclk <= ~spi_sclk;
            edge_cnt <= edge_cnt + EDGE_W'(1);
            if (do_sample) rx_sh <= rx_nxt;
            if (do_shift) begin
              tx_sh    <= tx_nxt;
              spi_mosi <= mosi_nxt;
            end
            if (last) state <= HOLD;
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rx_sh;
            state     <= DONE;
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        DONE: begin
          spi_sclk <= cpol_q;
          if (!hold_q) spi_ss <= '1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// tb_spi_master_mc: scoreboard bench for spi_master_mc, one MSB-first and
// one LSB-first instance, loopback or bench slave on MISO.
module tb_spi_master_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       cmd_valid_a, cmd_valid_b;
  logic [7:0] cmd_data;
  logic [2:0] cmd_ss_sel;
  logic       cmd_hold_ss, cfg_cpol, cfg_cpha;
  logic [7:0] cfg_div;

  logic       cmd_ready_a, rsp_valid_a, busy_a;
  logic       sclk_a, mosi_a, miso_a;
  logic [7:0] rsp_data_a;
  logic [1:0] ss_a;
  logic       cmd_ready_b, rsp_valid_b, busy_b;
  logic       sclk_b, mosi_b, miso_b;
  logic [7:0] rsp_data_b;
  logic [1:0] ss_b;

  logic       loop_a, slv_en, slv_cpol, slv_miso;
  logic [7:0] slv_tx, slv_rx;

  assign miso_a = loop_a ? mosi_a : slv_miso;
  assign miso_b = mosi_b;

  spi_master_mc #(.DATA_W(8), .NUM_SS(2), .DIV_W(8), .LSB_FIRST(0)) u_a (
    .mainClk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_data(cmd_data), .cmd_ss_sel(cmd_ss_sel),
    .cmd_hold_ss(cmd_hold_ss), .cfg_cpol(cfg_cpol),
    .cfg_cpha(cfg_cpha), .cfg_div(cfg_div),
    .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .busy(busy_a),
    .spi_ss(ss_a), .spi_sclk(sclk_a), .spi_mosi(mosi_a),
    .spi_miso(miso_a)
  );

  spi_master_mc #(.DATA_W(8), .NUM_SS(2), .DIV_W(8), .LSB_FIRST(1)) u_b (
    .mainClk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_data(cmd_data), .cmd_ss_sel(cmd_ss_sel),
    .cmd_hold_ss(cmd_hold_ss), .cfg_cpol(cfg_cpol),
    .cfg_cpha(cfg_cpha), .cfg_div(cfg_div),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .busy(busy_b),
    .spi_ss(ss_b), .spi_sclk(sclk_b), .spi_mosi(mosi_b),
    .spi_miso(miso_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid_a) begin
      check("rsp_a_expected", int'(q_a.size() > 0), 1);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("rsp_a_data", rsp_data_a, e.data);
        check("rsp_a_cycle", cyc, e.cyc);
      end
    end
    if (rsp_valid_b) begin
      check("rsp_b_expected", int'(q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("rsp_b_data", rsp_data_b, e.data);
        check("rsp_b_cycle", cyc, e.cyc);
      end
    end
  end

  // Per-cycle activity counters, sampled just after each edge.
  int   edges_a = 0, ss1_hi = 0, ss_act = 0, mosi_b_hi = 0;
  logic sclk_last_a = 1'b0;
  always @(posedge clk) begin
    #1;
    if (sclk_a !== sclk_last_a) edges_a++;
    sclk_last_a = sclk_a;
    if (ss_a[1] === 1'b1) ss1_hi++;
    if (ss_a !== 2'b11) ss_act++;
    if (mosi_b === 1'b1) mosi_b_hi++;
  end

  // Mode-3 style slave: drive on leading edge, capture on trailing edge.
  always @(sclk_a) begin
    if (slv_en && ss_a[0] == 1'b0) begin
      if (sclk_a != slv_cpol) begin
        slv_miso = slv_tx[7];
        slv_tx   = {slv_tx[6:0], 1'b0};
      end else begin
        slv_rx = {slv_rx[6:0], mosi_a};
      end
    end
  end

  task automatic send(input bit b, input logic [7:0] d,
                      input logic [2:0] sel, input logic hold,
                      input logic cpol, input logic cpha,
                      input logic [7:0] div, input logic [7:0] exp_d,
                      input bit expect_rsp, output int t);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    cmd_data = d; cmd_ss_sel = sel; cmd_hold_ss = hold;
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_div = div;
    if (b) cmd_valid_b = 1'b1;
    else   cmd_valid_a = 1'b1;
    while (!(b ? cmd_ready_b : cmd_ready_a) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept_in_time", int'(n < 500), 1);
    t = cyc;
    if (expect_rsp) begin
      e.data = exp_d;
      e.cyc  = t + 1 + 18 * (int'(div) + 1);
      if (b) q_b.push_back(e);
      else   q_a.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    cmd_data = ~d; cfg_cpol = ~cpol; cfg_cpha = ~cpha;
    cfg_div = ~div; cmd_hold_ss = ~hold; cmd_ss_sel = sel + 3'd1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2, base, base2, n;
    resetn = 1'b0; cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    cmd_data = 8'h00; cmd_ss_sel = 3'd0; cmd_hold_ss = 1'b0;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = 8'd0;
    loop_a = 1'b1; slv_en = 1'b0; slv_cpol = 1'b0;
    slv_miso = 1'b0; slv_tx = 8'h00; slv_rx = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_rsp_valid", rsp_valid_a, 0);
    check("rst_rsp_data", rsp_data_a, 8'h00);
    check("rst_ss", ss_a, 2'b11);
    check("rst_sclk", sclk_a, 0);
    check("rst_mosi", mosi_a, 0);
    resetn = 1'b1;

    // Mode 0, H=2, loopback 0xA5 on sel 0.
    send(0, 8'hA5, 3'd0, 0, 0, 0, 8'd1, 8'hA5, 1, t);
    @(negedge clk);
    check("t1_ss_assert", ss_a, 2'b10);
    check("t1_busy", busy_a, 1);
    check("t1_ready_low", cmd_ready_a, 0);
    check("t1_first_bit", mosi_a, 1);
    base = edges_a;
    wait_cyc(t + 2 + 18 * 2);
    check("t1_ss_release", ss_a, 2'b11);
    check("t1_sclk_edges", edges_a - base, 16);
    check("t1_sclk_idle", sclk_a, 0);

    // Mode 3, H=1, slave returns 0x3C while master sends 0xF0.
    loop_a = 1'b0; slv_tx = 8'h3C; slv_rx = 8'h00;
    send(0, 8'hF0, 3'd0, 0, 1, 1, 8'd0, 8'h3C, 1, t);
    @(negedge clk);
    check("t2_sclk_idle_high", sclk_a, 1);
    slv_cpol = 1'b1; slv_en = 1'b1;
    base = edges_a;
    wait_cyc(t + 2 + 18);
    check("t2_slave_rx", slv_rx, 8'hF0);
    check("t2_sclk_edges", edges_a - base, 16);
    check("t2_sclk_end", sclk_a, 1);
    slv_en = 1'b0; loop_a = 1'b1;

    // LSB first, mode 1, H=2: bit 0 cell is SETUP plus 3 half-periods.
    base = mosi_b_hi;
    send(1, 8'h01, 3'd0, 0, 0, 1, 8'd1, 8'h01, 1, t);
    @(negedge clk);
    check("t3_first_bit", mosi_b, 1);
    wait_cyc(t + 2 + 18 * 2);
    check("t3_mosi_high_cycles", mosi_b_hi - base, 8);

    // Held SS across back-to-back transfers, then switch slave.
    send(0, 8'h11, 3'd1, 1, 0, 0, 8'd0, 8'h11, 1, t1);
    @(negedge clk);
    check("t4_ss1_assert", ss_a, 2'b01);
    base = ss1_hi;
    send(0, 8'h22, 3'd1, 1, 0, 0, 8'd0, 8'h22, 1, t2);
    check("t4_b2b_accept", t2, t1 + 20);
    send(0, 8'h33, 3'd0, 0, 0, 0, 8'd0, 8'h33, 1, t);
    check("t4_third_accept", t, t2 + 20);
    @(negedge clk);
    check("t4_ss_switch", ss_a, 2'b10);
    check("t4_ss1_high_cycles", ss1_hi - base, 1);
    wait_cyc(t + 2 + 18);
    check("t4_ss_release", ss_a, 2'b11);

    // Reset pulse around the 4th SCLK edge; no response may follow.
    send(0, 8'h5A, 3'd0, 0, 0, 0, 8'd1, 8'h00, 0, t);
    @(negedge clk);
    base = edges_a;
    n = 0;
    while (edges_a - base < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_edge3", int'(n < 200), 1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("t5_ss", ss_a, 2'b11);
    check("t5_sclk", sclk_a, 0);
    check("t5_busy", busy_a, 0);
    check("t5_ready", cmd_ready_a, 1);
    check("t5_mosi", mosi_a, 0);
    resetn = 1'b1;
    repeat (60) @(negedge clk);

    // Out-of-range select: no SS, transfer still runs.
    base2 = ss_act;
    send(0, 8'hC3, 3'd5, 0, 0, 0, 8'd0, 8'hC3, 1, t);
    @(negedge clk);
    base = edges_a;
    wait_cyc(t + 2 + 18);
    check("t6_no_ss", ss_act - base2, 0);
    check("t6_sclk_edges", edges_a - base, 16);
    check("t6_busy_done", busy_a, 0);

    repeat (5) @(negedge clk);
    check("queue_a_empty", q_a.size(), 0);
    check("queue_b_empty", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
